// File: rtl/dphy_lane_seq.sv
// dphy_lane_seq: MIPI D-PHY data lane sequencer (LP request/prepare, HS-zero, sync, payload, trail, exit).
// Optional byte_count output is compiled in when DPHY_LANE_SEQ_BYTECNT_EN is defined.
module dphy_lane_seq #(
  parameter int T_LPX        = 4,
  parameter int T_HS_PREPARE = 4,
  parameter int T_HS_ZERO    = 12,
  parameter int T_HS_TRAIL   = 8,
  parameter int T_HS_EXIT    = 8
) (
  input  logic        dphy_clk,
  input  logic        areset,
  input  logic        tx_req,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic [1:0]  hs_dout,
  output logic        hs_oe,
  output logic        lp_p,
  output logic        lp_n,
  output logic        busy
`ifdef DPHY_LANE_SEQ_BYTECNT_EN
  ,
  output logic [15:0] byte_count
`endif
);
  typedef enum logic [2:0] {STOP, HS_RQST, HS_PREP, HS_ZERO, SYNC, DATA, TRAIL, EXIT} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hB8;
  state_t st, st_n;
  logic [7:0] tmr, tmr_n, sh, sh_n;
  logic last, last_n, done, acc;
  logic [1:0] k, dout_n, lp_nxt;
  logic oe_n, rdy_n, busy_n;
  assign done = tmr == 8'd0;
  assign acc  = tx_ready & tx_valid;
  // sh holds the byte on the wire; it keeps the last one through TRAIL so bit 7 sets the trail level
  always_comb begin
    st_n   = st;
    tmr_n  = done ? 8'd0 : tmr - 8'd1;
    sh_n   = sh;
    last_n = last;
    case (st)
      STOP:    if (tx_req) begin st_n = HS_RQST; tmr_n = 8'(T_LPX - 1); end
      HS_RQST: if (done) begin st_n = HS_PREP; tmr_n = 8'(T_HS_PREPARE - 1); end
      HS_PREP: if (done) begin st_n = HS_ZERO; tmr_n = 8'(T_HS_ZERO - 1); end
      HS_ZERO: if (done) begin st_n = SYNC; tmr_n = 8'd3; sh_n = SYNC_BYTE; last_n = 1'b0; end
      SYNC, DATA:
        if (done && acc) begin
          st_n = DATA; tmr_n = 8'd3; sh_n = tx_data; last_n = tx_last;
        end else if (done) begin
          st_n = TRAIL; tmr_n = 8'(T_HS_TRAIL - 1);
        end
      TRAIL:   if (done) begin st_n = EXIT; tmr_n = 8'(T_HS_EXIT - 1); end
      EXIT:    if (done) begin st_n = STOP; tmr_n = 8'd0; end
      default: st_n = STOP;
    endcase
    k      = ~tmr_n[1:0];
    busy_n = st_n != STOP;
    lp_nxt = (st_n == STOP || st_n == EXIT) ? 2'b11 : st_n == HS_RQST ? 2'b01 : 2'b00;
    oe_n   = st_n == HS_ZERO || st_n == SYNC || st_n == DATA || st_n == TRAIL;
    dout_n = (st_n == SYNC || st_n == DATA) ? sh_n[{k, 1'b0} +: 2] :
             st_n == TRAIL ? {2{~sh_n[7]}} : 2'b00;
    rdy_n  = (st_n == SYNC || (st_n == DATA && !last_n)) && tmr_n == 8'd0;
  end
  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      st       <= STOP;
      tmr      <= 8'd0;
      sh       <= 8'd0;
      last     <= 1'b0;
      tx_ready <= 1'b0;
      hs_dout  <= 2'b00;
      hs_oe    <= 1'b0;
      lp_p     <= 1'b1;
      lp_n     <= 1'b1;
      busy     <= 1'b0;
    end else begin
      st       <= st_n;
      tmr      <= tmr_n;
      sh       <= sh_n;
      last     <= last_n;
      tx_ready <= rdy_n;
      hs_dout  <= dout_n;
      hs_oe    <= oe_n;
      {lp_p, lp_n} <= lp_nxt;
      busy     <= busy_n;
    end
  end
`ifdef DPHY_LANE_SEQ_BYTECNT_EN
  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) byte_count <= 16'd0;
    else if (st == STOP && tx_req) byte_count <= 16'd0;
    else if (acc && byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_dphy_lane_seq.sv
// tb_dphy_lane_seq: scoreboard bench; a lane model queues per-cycle expected outputs and stimulus.
module tb_dphy_lane_seq;
  localparam int LPX = 4, PRE = 4, ZRO = 12, TRL = 8, EXT = 8;
  typedef struct packed {logic [1:0] lp; logic oe; logic [1:0] d; logic b; logic r;} out_t;
  typedef struct packed {logic v; logic [7:0] d; logic l;} in_t;
  localparam out_t STOP_O = 7'b11_0_00_0_0;
  logic dphy_clk = 1'b0, areset = 1'b1, tx_req = 1'b0, tx_valid = 1'b0, tx_last = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, hs_oe, lp_p, lp_n, busy;
  logic [1:0] hs_dout;
  int n_chk = 0, n_err = 0;
  out_t exp_q[$];
  in_t stim_q[$];
  logic [7:0] bytes_q[$];
`ifdef DPHY_LANE_SEQ_BYTECNT_EN
  logic [15:0] byte_count;
`endif
  dphy_lane_seq #(.T_LPX(LPX), .T_HS_PREPARE(PRE), .T_HS_ZERO(ZRO), .T_HS_TRAIL(TRL), .T_HS_EXIT(EXT)) dut (
    .dphy_clk(dphy_clk), .areset(areset), .tx_req(tx_req), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .hs_dout(hs_dout), .hs_oe(hs_oe), .lp_p(lp_p), .lp_n(lp_n),
    .busy(busy)
`ifdef DPHY_LANE_SEQ_BYTECNT_EN
    , .byte_count(byte_count)
`endif
  );
  always #5 dphy_clk = ~dphy_clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic out_t act();
    return {lp_p, lp_n, hs_oe, hs_dout, busy, tx_ready};
  endfunction
  function automatic out_t mk(input logic [1:0] lp, input logic oe, input logic [1:0] d, input logic b, input logic r);
    return {lp, oe, d, b, r};
  endfunction
  function automatic in_t junk();
    return {1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1))};
  endfunction
  task automatic push(input out_t o, input in_t s);
    exp_q.push_back(o);
    stim_q.push_back(s);
  endtask
  // n bytes from bytes_q are offered; with use_last the final one carries tx_last, otherwise an underrun follows
  task automatic build(input int n, input logic use_last);
    logic [7:0] cur;
    logic lb, rdy;
    in_t s;
    for (int c = 0; c < LPX; c++) push(mk(2'b01, 1'b0, 2'b00, 1'b1, 1'b0), junk());
    for (int c = 0; c < PRE; c++) push(mk(2'b00, 1'b0, 2'b00, 1'b1, 1'b0), junk());
    for (int c = 0; c < ZRO; c++) push(mk(2'b00, 1'b1, 2'b00, 1'b1, 1'b0), junk());
    cur = 8'hB8;
    for (int k = 0; k < 4; k++) begin
      s = junk();
      if (k == 3) s = n > 0 ? {1'b1, bytes_q[0], use_last && n == 1} : {1'b0, 8'($urandom), 1'b1};
      push(mk(2'b00, 1'b1, cur[2*k +: 2], 1'b1, k == 3), s);
    end
    lb = 1'b1;
    for (int i = 0; i < n; i++) begin
      cur = bytes_q[i];
      for (int k = 0; k < 4; k++) begin
        rdy = k == 3 && !(use_last && i == n - 1);
        s = junk();
        if (rdy) s = i + 1 < n ? {1'b1, bytes_q[i+1], use_last && i + 1 == n - 1} : {1'b0, 8'($urandom), 1'b0};
        push(mk(2'b00, 1'b1, cur[2*k +: 2], 1'b1, rdy), s);
      end
      lb = cur[7];
    end
    for (int c = 0; c < TRL; c++) push(mk(2'b00, 1'b1, {2{~lb}}, 1'b1, 1'b0), junk());
    for (int c = 0; c < EXT; c++) push(mk(2'b11, 1'b0, 2'b00, 1'b1, 1'b0), junk());
    push(STOP_O, junk());
  endtask
  task automatic chk_bcnt(input int n);
`ifdef DPHY_LANE_SEQ_BYTECNT_EN
    chk("byte_count", 32'(byte_count), 32'(n));
`else
    if (n < 0) chk("byte_count_arg", 32'(n), 32'd0);
`endif
  endtask
  task automatic run(input logic hold, input int abort_at);
    int i = 0;
    out_t e;
    in_t s;
    tx_req = 1'b1;
    @(posedge dphy_clk);
    while (exp_q.size() > 0) begin
      @(negedge dphy_clk);
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      chk($sformatf("cyc%0d", i), 32'(act()), 32'(e));
      {tx_valid, tx_data, tx_last} = s;
      tx_req = exp_q.size() > 0 && (hold || 1'($urandom_range(0, 1)));
      if (i == abort_at) begin
        areset = 1'b1;
        #1;
        chk("rst_mid", 32'(act()), 32'(STOP_O));
        chk_bcnt(0);
        exp_q.delete();
        stim_q.delete();
      end
      i++;
    end
    tx_req = 1'b0;
    tx_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge dphy_clk);
      chk("idle", 32'(act()), 32'(STOP_O));
      {tx_valid, tx_data, tx_last} = junk();
    end
    tx_valid = 1'b0;
  endtask
  initial begin
    int n;
    logic ul;
    repeat (3) @(negedge dphy_clk);
    chk("in_reset", 32'(act()), 32'(STOP_O));
    chk_bcnt(0);
    areset = 1'b0;
    idle(3);
    build(0, 1'b0);
    run(1'b0, -1);
    chk_bcnt(0);
    bytes_q = '{8'h5A, 8'h81};
    build(2, 1'b1);
    run(1'b0, -1);
    chk_bcnt(2);
    bytes_q = '{8'h01};
    build(1, 1'b1);
    run(1'b0, -1);
    chk_bcnt(1);
    bytes_q = '{8'h3C, 8'h11, 8'h22};
    build(1, 1'b0);
    run(1'b0, -1);
    chk_bcnt(1);
    bytes_q = '{8'hA5, 8'hC3, 8'h0F};
    build(3, 1'b1);
    run(1'b0, LPX + PRE + ZRO + 4 + 5);
    @(negedge dphy_clk);
    chk("rst_hold", 32'(act()), 32'(STOP_O));
    areset = 1'b0;
    idle(2);
    build(3, 1'b1);
    run(1'b0, -1);
    chk_bcnt(3);
    bytes_q = '{8'hE7, 8'h18};
    build(2, 1'b0);
    build(2, 1'b1);
    run(1'b1, -1);
    chk_bcnt(2);
    for (int t = 0; t < 5; t++) begin
      n = $urandom_range(1, 4);
      ul = 1'($urandom_range(0, 1));
      bytes_q.delete();
      for (int j = 0; j < n; j++) bytes_q.push_back(8'($urandom));
      build(n, ul);
      run(1'b0, -1);
      chk_bcnt(n);
      idle(1);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dphy_lane_seq.md
DPHY_LANE_SEQ -- requirements
Module: dphy_lane_seq

Interface
REQ-001 Parameter T_LPX, default 4, LP-01 request duration in dphy_clk cycles (range 1..255).
REQ-002 Parameter T_HS_PREPARE, default 4, LP-00 prepare duration in cycles (1..255).
REQ-003 Parameter T_HS_ZERO, default 12, HS-0 duration before sync in cycles (1..255).
REQ-004 Parameter T_HS_TRAIL, default 8, HS trail duration in cycles (1..255).
REQ-005 Parameter T_HS_EXIT, default 8, minimum LP-11 hold after a burst in cycles (1..255).
REQ-006 dphy_clk  input  1  fast D-PHY DDR clock; all logic on its rising edge.
REQ-007 areset  input  1  asynchronous, active-high reset.
REQ-008 tx_req  input  1  request to start an HS burst.
REQ-009 tx_data  input  8  payload byte.
REQ-010 tx_valid  input  1  tx_data valid.
REQ-011 tx_last  input  1  qualifies tx_data as the final byte of the burst.
REQ-012 tx_ready  output  1  byte accept strobe; a transfer occurs when tx_valid and tx_ready are both high.
REQ-013 hs_dout  output  2  HS dibit to the DDR output primitive; bit 0 transmitted first.
REQ-014 hs_oe  output  1  HS driver enable.
REQ-015 lp_p, lp_n  output  1 each  LP line levels.
REQ-016 busy  output  1  high in every state except STOP.

Function
REQ-017 States: STOP, HS_RQST, HS_PREP, HS_ZERO, SYNC, DATA, TRAIL, EXIT; all outputs registered.
REQ-018 Each timed state lasts exactly its parameter in cycles; SYNC and each DATA byte last exactly 4 cycles.
REQ-019 STOP: lp=11, hs_oe=0, hs_dout=00; tx_req high in STOP moves to HS_RQST on the next cycle; tx_req is ignored in all other states.
REQ-020 HS_RQST: lp=01, hs_oe=0; HS_PREP: lp=00, hs_oe=0.
REQ-021 HS_ZERO: lp=00, hs_oe=1, hs_dout=00.
REQ-022 SYNC: transmits 0xB8 LSB first; hs_dout sequence 00, 10, 11, 10.
REQ-023 DATA: each byte is sent as dibits [1:0], [3:2], [5:4], [7:6] on consecutive cycles; lp=00, hs_oe=1.
REQ-024 tx_ready is high only on cycle 3 of SYNC and on cycle 3 of a DATA byte whose tx_last was not set; it is low in all other cycles.
REQ-025 A byte accepted on a tx_ready cycle is output starting on the next cycle with no gap.
REQ-026 If tx_valid is low on a tx_ready cycle (underrun), the next state is TRAIL; a burst of zero bytes (SYNC then TRAIL) is legal.
REQ-027 After a byte accepted with tx_last high completes its 4 cycles, the next state is TRAIL.
REQ-028 TRAIL: hs_oe=1; both hs_dout bits equal the inverse of the last transmitted bit (bit 7 of the last byte, or 1 for the sync byte, so 00 after a zero-byte burst).
REQ-029 EXIT: lp=11, hs_oe=0, hs_dout=00; afterwards return to STOP. A tx_req held high starts the next burst one cycle after STOP is entered.
REQ-030 The state timer is 8 bits wide and loaded with the parameter minus 1 on state entry; it never wraps.

Reset
REQ-031 areset forces STOP immediately at any point, including mid-burst: lp_p=1, lp_n=1, hs_oe=0, hs_dout=00, tx_ready=0, busy=0, timer=0, and byte_count=0 when compiled in.
REQ-032 After areset deasserts, the first state change occurs on a dphy_clk edge that samples tx_req high.

Configuration
REQ-033 Macro DPHY_LANE_SEQ_BYTECNT_EN: when defined, the block adds output byte_count (16 bits).
REQ-034 byte_count clears on entry to HS_RQST, increments on each accepted byte, saturates at 0xFFFF, and holds its value after the burst.
REQ-035 When DPHY_LANE_SEQ_BYTECNT_EN is not defined, the byte_count port and its logic are absent and all other behaviour is identical.

Verification
REQ-036 tx_req pulse with default parameters and tx_valid held low -> lp 11→01 (4 cycles)→00 (4)→hs_oe=1 with 00 for 12 cycles, then 00,10,11,10, then trail 00 for 8 cycles, then lp 11 with busy high for 8 cycles, then STOP.
REQ-037 Bytes 0x5A, then 0x81 with tx_last, both presented at the first tx_ready -> dibits 10,10,01,01,01,00,00,10; trail 00 (bit 7 of 0x81 is 1); 2 accept strobes; byte_count=2 when compiled in.
REQ-038 Single byte 0x01 with tx_last -> tx_ready low during that byte; trail hs_dout=11 for 8 cycles.
REQ-039 tx_valid dropped at the second tx_ready of a 3-byte stream -> exactly 1 byte transmitted, then TRAIL, with no further tx_ready.
REQ-040 areset asserted in the middle of a DATA byte -> same cycle lp=11, hs_oe=0, tx_ready=0, busy=0; a new tx_req after release restarts the full sequence.
REQ-041 tx_req held high continuously -> back-to-back bursts, each separated by exactly T_HS_EXIT cycles of EXIT plus one STOP cycle.
